// File: rtl/sd_block_server_if.sv
// ---------------------------------------------------------------------------
// sd_block_server_if
// Bundles the two buses of the sector server:
//   - client side: sd_lba/sd_rd/sd_wr requests, sd_ack, and the sd_buff_* byte port
//   - backing memory side: mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata/mem_ready
//   - oob: out-of-range / write-protect pulse raised when a request is accepted
// Modports:
//   slave  - the sector server (answers requests, masters the backing memory)
//   master - the client/bench view (raises requests, serves the backing memory)
// ---------------------------------------------------------------------------
interface sd_block_server_if #(
    parameter int MEM_AW = 20
);
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din;
    logic              sd_buff_wr;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic              oob;

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_wdata, oob
    );

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_wdata, oob
    );
endinterface

// File: rtl/sd_block_server.sv
// ---------------------------------------------------------------------------
// sd_block_server
// Host-side responder for the sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* sector
// protocol. Serves 512-byte sectors out of a byte-wide backing memory.
//
// Ports:
//   clk    - system clock, posedge
//   reset  - synchronous, active-high; aborts any transfer (no resume)
//   wp     - write protect (only when SD_BLOCK_SERVER_WP_EN is defined)
//   bus    - sd_block_server_if.slave: client request/ack/buffer port,
//            backing memory port (mem_addr = {lba[MEM_AW-10:0], idx[8:0]}),
//            and the oob pulse
//
// Optional feature: define SD_BLOCK_SERVER_WP_EN to add the wp input. A write
// accepted while wp=1 runs the normal ack/fetch sequence but never issues
// mem_wr, and is flagged on oob.
//
// Sequence: IDLE -> ACKDLY -> {RD_REQ <-> RD_PUT | WR_FETCH <-> WR_REQ} -> GAP
// -> IDLE. All outputs are registered.
// ---------------------------------------------------------------------------
module sd_block_server #(
    parameter int MEM_AW     = 20,
    parameter int IMG_BLOCKS = 342,
    parameter int ACK_DELAY  = 4,
    parameter int BUF_RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SD_BLOCK_SERVER_WP_EN
    input  logic              wp,
`endif
    sd_block_server_if.slave  bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACKDLY   = 3'd1;
    localparam logic [2:0] S_RD_REQ   = 3'd2;
    localparam logic [2:0] S_RD_PUT   = 3'd3;
    localparam logic [2:0] S_WR_FETCH = 3'd4;
    localparam logic [2:0] S_WR_REQ   = 3'd5;
    localparam logic [2:0] S_GAP      = 3'd6;

    localparam int          LBA_W      = MEM_AW - 9;
    localparam logic [3:0]  ACK_LAST   = 4'(ACK_DELAY - 1);
    // Address is driven on entry to WR_FETCH; sampling BUF_RD_LAT+1 edges
    // later leaves a full cycle of margin on the client's read latency.
    localparam logic [3:0]  FETCH_LAST = 4'(BUF_RD_LAT);
    localparam logic [3:0]  GAP_LAST   = 4'd1;
    localparam logic [9:0]  LAST_IDX   = 10'd511;

    logic [2:0]        state;
    logic [3:0]        cnt;
    logic [9:0]        idx;        // 10 bits so the end test never wraps to byte 0
    logic [9:0]        idx_nxt;
    logic [LBA_W-1:0]  lba_q;
    logic              dir_wr;
    logic              sup;        // suppress memory access (out of range / protected)

    logic              ack_q;
    logic              buff_wr_q;
    logic [8:0]        buff_addr_q;
    logic [7:0]        dout_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              oob_q;

    logic              req_oob;
    logic              wp_hit;

    assign idx_nxt = idx + 10'd1;
    // Range check on the full 32-bit lba, not the truncated memory address.
    assign req_oob = bus.sd_lba >= 32'(IMG_BLOCKS);

`ifdef SD_BLOCK_SERVER_WP_EN
    // Only a write can violate protection; read wins when both are raised.
    assign wp_hit = ~bus.sd_rd & bus.sd_wr & wp;
`else
    assign wp_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            lba_q       <= '0;
            dir_wr      <= 1'b0;
            sup         <= 1'b0;
            ack_q       <= 1'b0;
            buff_wr_q   <= 1'b0;
            buff_addr_q <= '0;
            dout_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            oob_q       <= 1'b0;
        end else begin
            oob_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.sd_rd | bus.sd_wr) begin
                        lba_q  <= bus.sd_lba[LBA_W-1:0];
                        dir_wr <= ~bus.sd_rd;
                        sup    <= req_oob | wp_hit;
                        oob_q  <= req_oob | wp_hit;
                        idx    <= '0;
                        cnt    <= '0;
                        state  <= S_ACKDLY;
                    end
                end

                S_ACKDLY: begin
                    if (cnt == ACK_LAST) begin
                        ack_q <= 1'b1;
                        cnt   <= '0;
                        if (dir_wr) begin
                            buff_addr_q <= '0;
                            state       <= S_WR_FETCH;
                        end else if (sup) begin
                            // Out-of-range read: zero bytes, one per cycle.
                            buff_wr_q   <= 1'b1;
                            buff_addr_q <= '0;
                            dout_q      <= '0;
                            state       <= S_RD_PUT;
                        end else begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= {lba_q, 9'd0};
                            state      <= S_RD_REQ;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                S_RD_REQ: begin
                    if (bus.mem_ready) begin
                        mem_rd_q    <= 1'b0;
                        buff_wr_q   <= 1'b1;
                        buff_addr_q <= idx[8:0];
                        dout_q      <= bus.mem_rdata;
                        state       <= S_RD_PUT;
                    end
                end

                // The strobe for byte idx is high while in this state.
                S_RD_PUT: begin
                    if (idx == LAST_IDX) begin
                        buff_wr_q <= 1'b0;
                        ack_q     <= 1'b0;
                        cnt       <= '0;
                        state     <= S_GAP;
                    end else begin
                        idx <= idx_nxt;
                        if (sup) begin
                            buff_wr_q   <= 1'b1;
                            buff_addr_q <= idx_nxt[8:0];
                            dout_q      <= '0;
                        end else begin
                            buff_wr_q  <= 1'b0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= {lba_q, idx_nxt[8:0]};
                            state      <= S_RD_REQ;
                        end
                    end
                end

                S_WR_FETCH: begin
                    if (cnt == FETCH_LAST) begin
                        cnt <= '0;
                        if (!sup) begin
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= {lba_q, idx[8:0]};
                            mem_wdata_q <= bus.sd_buff_din;
                            state       <= S_WR_REQ;
                        end else if (idx == LAST_IDX) begin
                            ack_q <= 1'b0;
                            state <= S_GAP;
                        end else begin
                            idx         <= idx_nxt;
                            buff_addr_q <= idx_nxt[8:0];
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                S_WR_REQ: begin
                    if (bus.mem_ready) begin
                        mem_wr_q <= 1'b0;
                        cnt      <= '0;
                        if (idx == LAST_IDX) begin
                            ack_q <= 1'b0;
                            state <= S_GAP;
                        end else begin
                            idx         <= idx_nxt;
                            buff_addr_q <= idx_nxt[8:0];
                            state       <= S_WR_FETCH;
                        end
                    end
                end

                // Two idle cycles with sd_ack low before looking at requests again.
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sd_ack       = ack_q;
    assign bus.sd_buff_wr   = buff_wr_q;
    assign bus.sd_buff_addr = buff_addr_q;
    assign bus.sd_buff_dout = dout_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.mem_wr       = mem_wr_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.oob          = oob_q;

endmodule

// File: tb/tb_sd_block_server.sv
// ---------------------------------------------------------------------------
// tb_sd_block_server
// Directed bench for sd_block_server. Backing memory image is
// mem[a] = a[7:0]^a[15:8] with 0..3 cycles of random ready latency; the
// client write buffer holds byte i = ~i[7:0] with a registered read path.
// Expected sd_buff writes and memory writes are queued when a transfer starts
// and popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_sd_block_server;

    logic clk = 1'b0;
    logic reset;
`ifdef SD_BLOCK_SERVER_WP_EN
    logic wp;
`endif

    always #5 clk = ~clk;

    sd_block_server_if #(.MEM_AW(20)) bus ();

    sd_block_server #(
        .MEM_AW(20), .IMG_BLOCKS(342), .ACK_DELAY(4), .BUF_RD_LAT(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SD_BLOCK_SERVER_WP_EN
        .wp    (wp),
`endif
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [27:0] rq[$];   // {11'b0, sd_buff_addr, sd_buff_dout}
    logic [27:0] wq[$];   // {mem_addr, mem_wdata}

    int cyc = 0;
    int rd_pulses = 0;
    int oob_cnt = 0;
    int mem_rd_cyc = 0;
    int wr_hs = 0;
    int last_wr_cyc = 0;
    int fall_cyc = 0;
    logic prev_ack = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [19:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input logic [19:0] base, input logic zero);
        for (int i = 0; i < 512; i++)
            rq.push_back({11'd0, 9'(i), zero ? 8'h00 : mem_byte(base + 20'(i))});
    endtask

    task automatic push_wr(input logic [19:0] base);
        for (int i = 0; i < 512; i++)
            wq.push_back({base + 20'(i), ~8'(i)});
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n;
        n = 0;
        while (bus.sd_ack !== lvl && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.sd_ack), 32'(lvl));
    endtask

    task automatic start(input logic [31:0] lba, input logic rd, input logic wr);
        @(negedge clk);
        rd_pulses  = 0;
        oob_cnt    = 0;
        mem_rd_cyc = 0;
        wr_hs      = 0;
        bus.sd_lba = lba;
        bus.sd_rd  = rd;
        bus.sd_wr  = wr;
    endtask

    // Wait for ack, drop the requests selected by the mask, wait for the end
    // of the sector and the trailing gap.
    task automatic finish_xfer(input logic drop_rd, input logic drop_wr, input string tag);
        wait_ack(1'b1, {tag, "_ack_rise"});
        @(negedge clk);
        if (drop_rd) bus.sd_rd = 1'b0;
        if (drop_wr) bus.sd_wr = 1'b0;
        wait_ack(1'b0, {tag, "_ack_fall"});
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // Client-side monitor: scoreboard for sd_buff writes plus event counters.
    always @(negedge clk) begin
        logic [27:0] e;
        if (bus.sd_buff_wr) begin
            rd_pulses++;
            last_wr_cyc = cyc;
            e = (rq.size() > 0) ? rq.pop_front() : 28'hFFFFFFF;
            chk("sd_buff_wr", 32'({11'd0, bus.sd_buff_addr, bus.sd_buff_dout}), 32'(e));
        end
        if (bus.oob) oob_cnt++;
        if (bus.mem_rd) mem_rd_cyc++;
        if (prev_ack && !bus.sd_ack) fall_cyc = cyc;
        prev_ack = bus.sd_ack;
    end

    // Backing memory model with random ready latency.
    initial begin
        logic pending;
        int lat;
        logic [27:0] e;
        pending = 1'b0;
        lat = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (bus.mem_rd || bus.mem_wr) begin
                if (!pending) begin
                    pending = 1'b1;
                    lat = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    pending = 1'b0;
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_byte(bus.mem_addr);
                    if (bus.mem_wr) begin
                        wr_hs++;
                        e = (wq.size() > 0) ? wq.pop_front() : 28'hFFFFFFF;
                        chk("mem_wr", 32'({bus.mem_addr, bus.mem_wdata}), 32'(e));
                    end
                end else begin
                    lat--;
                end
            end else begin
                pending = 1'b0;
            end
        end
    end

    // Client buffer: byte i = ~i, two-register read path from sd_buff_addr.
    initial begin
        logic [7:0] d1;
        d1 = 8'h00;
        bus.sd_buff_din = 8'h00;
        forever begin
            @(negedge clk);
            bus.sd_buff_din = d1;
            d1 = ~bus.sd_buff_addr[7:0];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        bus.sd_lba = '0;
        bus.sd_rd  = 1'b0;
        bus.sd_wr  = 1'b0;
`ifdef SD_BLOCK_SERVER_WP_EN
        wp = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ack",      32'(bus.sd_ack),       32'd0);
        chk("rst_buff_wr",  32'(bus.sd_buff_wr),   32'd0);
        chk("rst_buff_adr", 32'(bus.sd_buff_addr), 32'd0);
        chk("rst_dout",     32'(bus.sd_buff_dout), 32'd0);
        chk("rst_mem_rd",   32'(bus.mem_rd),       32'd0);
        chk("rst_mem_wr",   32'(bus.mem_wr),       32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr),     32'd0);
        chk("rst_wdata",    32'(bus.mem_wdata),    32'd0);
        chk("rst_oob",      32'(bus.oob),          32'd0);
        reset = 1'b0;

        // Read lba 5: ack latency, full sector, fall timing
        push_rd(20'hA00, 1'b0);
        start(32'd5, 1'b1, 1'b0);
        @(posedge clk);              // accept edge
        n = 0;
        while (!bus.sd_ack && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ack_delay", 32'(n), 32'd4);
        finish_xfer(1'b1, 1'b0, "rd5");
        chk("rd5_pulses",   32'(rd_pulses),        32'd512);
        chk("rd5_rq_empty", 32'(rq.size()),        32'd0);
        chk("rd5_fall_lag", 32'(fall_cyc - last_wr_cyc), 32'd1);
        chk("rd5_oob",      32'(oob_cnt),          32'd0);
        chk("rd5_addr_hold",32'(bus.sd_buff_addr), 32'd511);

        // Write lba 3 with random memory latency
        push_wr(20'h600);
        start(32'd3, 1'b0, 1'b1);
        finish_xfer(1'b0, 1'b1, "wr3");
        chk("wr3_hs",        32'(wr_hs),            32'd512);
        chk("wr3_wq_empty",  32'(wq.size()),        32'd0);
        chk("wr3_oob",       32'(oob_cnt),          32'd0);
        chk("wr3_addr_hold", 32'(bus.sd_buff_addr), 32'd511);
        chk("wr3_no_bufwr",  32'(rd_pulses),        32'd0);

        // Out-of-range read at the first invalid block
        push_rd(20'h0, 1'b1);
        start(32'd342, 1'b1, 1'b0);
        finish_xfer(1'b1, 1'b0, "oob");
        chk("oob_pulses",   32'(rd_pulses),  32'd512);
        chk("oob_rq_empty", 32'(rq.size()),  32'd0);
        chk("oob_count",    32'(oob_cnt),    32'd1);
        chk("oob_no_memrd", 32'(mem_rd_cyc), 32'd0);

        // Last valid block reads normally
        push_rd(20'({9'd341, 9'd0}), 1'b0);
        start(32'd341, 1'b1, 1'b0);
        finish_xfer(1'b1, 1'b0, "last");
        chk("last_rq_empty", 32'(rq.size()), 32'd0);
        chk("last_oob",      32'(oob_cnt),   32'd0);

        // Write with high lba bits set: out of range despite small truncated address
        start(32'h8000_0001, 1'b0, 1'b1);
        finish_xfer(1'b0, 1'b1, "oobw");
        chk("oobw_oob",   32'(oob_cnt),          32'd1);
        chk("oobw_no_wr", 32'(wr_hs),            32'd0);
        chk("oobw_addr",  32'(bus.sd_buff_addr), 32'd511);

        // Priority: read first, then the still-pending write
        push_rd(20'h200, 1'b0);
        push_wr(20'h200);
        start(32'd1, 1'b1, 1'b1);
        finish_xfer(1'b1, 1'b0, "pri_rd");
        chk("pri_rd_done",  32'(rq.size()), 32'd0);
        chk("pri_no_wr_yet",32'(wr_hs),     32'd0);
        finish_xfer(1'b0, 1'b1, "pri_wr");
        chk("pri_wr_done",  32'(wq.size()), 32'd0);
        chk("pri_wr_hs",    32'(wr_hs),     32'd512);

        // Reset in the middle of a read
        push_rd(20'hE00, 1'b0);
        start(32'd7, 1'b1, 1'b0);
        n = 0;
        while (rd_pulses < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached", 32'(rd_pulses >= 100), 32'd1);
        bus.sd_rd = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ack",     32'(bus.sd_ack),     32'd0);
        chk("mid_buff_wr", 32'(bus.sd_buff_wr), 32'd0);
        chk("mid_mem_rd",  32'(bus.mem_rd),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        rq.delete();
        push_rd(20'h400, 1'b0);
        start(32'd2, 1'b1, 1'b0);
        wait_ack(1'b1, "post_ack_rise");
        chk("post_mem_rd",   32'(bus.mem_rd),   32'd1);
        chk("post_mem_addr", 32'(bus.mem_addr), 32'h400);
        finish_xfer(1'b1, 1'b0, "post");
        chk("post_pulses",   32'(rd_pulses), 32'd512);
        chk("post_rq_empty", 32'(rq.size()), 32'd0);

`ifdef SD_BLOCK_SERVER_WP_EN
        // Write-protected write: full fetch sequence, no memory writes
        wp = 1'b1;
        start(32'd0, 1'b0, 1'b1);
        finish_xfer(1'b0, 1'b1, "wp");
        chk("wp_oob",   32'(oob_cnt),          32'd1);
        chk("wp_no_wr", 32'(wr_hs),            32'd0);
        chk("wp_addr",  32'(bus.sd_buff_addr), 32'd511);
        wp = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
